// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/capture/hold sequencer feeding a 4-bit combinational ALU.
// Define ALU_STATUS_FLAGS_EN to add registered res_zero/res_neg status outputs.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_s,
    input  logic [5:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [5:0] res_y,
    output logic [3:0] res_op,
`ifdef ALU_STATUS_FLAGS_EN
    output logic       res_zero,
    output logic       res_neg,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    state_t           state;
    logic [3:0]       mem_a  [DEPTH];
    logic [3:0]       mem_b  [DEPTH];
    logic [3:0]       mem_op [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty     = (count == {(PTR_W+1){1'b0}});
    assign cmd_ready = (count != FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;

    // Pop decision: only IDLE and the HOLD handshake edge take the next command.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) pop = 1'b1;
                else        pop = 1'b0;
            end
            HOLD: begin
                if (res_ready && !empty) pop = 1'b1;
                else                     pop = 1'b0;
            end
            default: pop = 1'b0;
        endcase
    end

    // FIFO storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at PTR_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            count  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push) wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            case ({push, pop})
                2'b10:   count <= count + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count <= count - {{PTR_W{1'b0}}, 1'b1};
                default: count <= count;
            endcase
        end
    end

    // Sequencer FSM with registered ALU drive and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= 4'd0;
            alu_b     <= 4'd0;
            alu_s     <= 4'd0;
            res_valid <= 1'b0;
            res_y     <= 6'd0;
            res_op    <= 4'd0;
`ifdef ALU_STATUS_FLAGS_EN
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a <= mem_a[rd_ptr];
                        alu_b <= mem_b[rd_ptr];
                        alu_s <= mem_op[rd_ptr];
                        state <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    // alu_s still carries the opcode of the command being captured
                    res_y     <= alu_y;
                    res_op    <= alu_s;
                    res_valid <= 1'b1;
`ifdef ALU_STATUS_FLAGS_EN
                    res_zero  <= (alu_y == 6'd0);
                    res_neg   <= alu_s[3] ? 1'b0 : alu_y[5];
`endif
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            alu_a <= mem_a[rd_ptr];
                            alu_b <= mem_b[rd_ptr];
                            alu_s <= mem_op[rd_ptr];
                            state <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus a randomized
// producer/consumer run scored against a queue-based reference and a behavioural ALU.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic [5:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_y;
    logic [3:0] res_op;
    logic       busy;
`ifdef ALU_STATUS_FLAGS_EN
    logic       res_zero;
    logic       res_neg;
`endif

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_op(res_op),
`ifdef ALU_STATUS_FLAGS_EN
        .res_zero(res_zero), .res_neg(res_neg),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: signed arithmetic for 0xxx, zero-extended logic for 1xxx.
    function automatic logic [5:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] op);
        int sa;
        int sb;
        int r;
        logic [3:0] l;
        sa = $signed(a);
        sb = $signed(b);
        r  = 0;
        l  = 4'd0;
        case (op)
            4'd0: r = sa + 1;
            4'd1: r = sa - 1;
            4'd2: r = sa + sb;
            4'd3: r = sa - sb;
            4'd4: r = sb - sa;
            4'd5: r = -sa;
            4'd6: r = sa * 2;
            4'd7: r = sa * 4;
            4'd8: l = ~a;
            4'd9: l = ~b;
            4'd10: l = a & b;
            4'd11: l = a | b;
            4'd12: l = a ^ b;
            4'd13: l = ~(a & b);
            4'd14: l = ~(a | b);
            default: l = ~(a ^ b);
        endcase
        if (op[3]) return {2'b00, l};
        return r[5:0];
    endfunction

    always_comb alu_y = alu_model(alu_a, alu_b, alu_s);

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int guard;
        guard = 0;
        cmd_a = a; cmd_b = b; cmd_op = op;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL push_timeout cmd_ready=%0b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 4'd0;
        #22;
        checks++;
        if ({res_valid, busy, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ctrl valid/busy/ready=%b required 001", {res_valid, busy, cmd_ready});
        end
        checks++;
        if ({alu_a, alu_b, alu_s, res_y, res_op} !== 22'd0) begin
            errors++;
            $display("FAIL reset_data got %h required 0", {alu_a, alu_b, alu_s, res_y, res_op});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Single op with latency: res_valid rises on the third edge after the push edge.
    task automatic test_single(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                               input logic [5:0] exp_y, input logic exp_zero, input logic exp_neg);
        push(a, b, op);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid op=%b res_valid=%b required 0", op, res_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || res_y !== exp_y || res_op !== op) begin
            errors++;
            $display("FAIL single op=%b got v=%b y=%b op=%b required v=1 y=%b op=%b",
                     op, res_valid, res_y, res_op, exp_y, op);
        end
`ifdef ALU_STATUS_FLAGS_EN
        checks++;
        if (res_zero !== exp_zero || res_neg !== exp_neg) begin
            errors++;
            $display("FAIL flags op=%b got z=%b n=%b required z=%b n=%b",
                     op, res_zero, res_neg, exp_zero, exp_neg);
        end
`else
        if (exp_zero && exp_neg) $display("note: inconsistent flag expectation");
`endif
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release op=%b v=%b busy=%b required 0 0", op, res_valid, busy);
        end
    endtask

    task automatic test_back_to_back;
        int seen;
        int t_first;
        logic [5:0] ys [2];
        int ts [2];
        seen = 0; t_first = 0;
        res_ready = 1'b1;
        push(4'b1100, 4'b1010, 4'b1010);
        push(4'b1100, 4'b1010, 4'b1100);
        for (int c = 0; c < 30 && seen < 2; c++) begin
            if (res_valid) begin
                ys[seen] = res_y;
                ts[seen] = c;
                seen++;
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        checks++;
        if (seen != 2) begin
            errors++;
            $display("FAIL b2b_count got %0d required 2", seen);
        end else begin
            checks++;
            if (ys[0] !== 6'b001000 || ys[1] !== 6'b000110) begin
                errors++;
                $display("FAIL b2b_order got %b %b required 001000 000110", ys[0], ys[1]);
            end
            checks++;
            if (ts[1] - ts[0] != 3) begin
                errors++;
                $display("FAIL b2b_gap got %0d required 3", ts[1] - ts[0]);
            end
        end
    endtask

    task automatic test_fill_backpressure;
        logic [3:0] qa [$];
        logic [3:0] qb [$];
        logic [3:0] qo [$];
        logic [5:0] held_y;
        logic [3:0] a, b, o;
        bit ok;
        int got;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 4'($urandom); b = 4'($urandom); o = 4'($urandom);
            qa.push_back(a); qb.push_back(b); qo.push_back(o);
            push(a, b, o);
        end
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_full cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
        end
        // A sixth command offered while full must be refused.
        cmd_a = 4'hF; cmd_b = 4'hF; cmd_op = 4'hF; cmd_valid = 1'b1;
        wait_valid(ok);
        held_y = res_y;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_y !== held_y) begin
                errors++;
                $display("FAIL hold_stable v=%b y=%b required 1 %b", res_valid, res_y, held_y);
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            if (res_valid) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL fill_extra y=%b required none", res_y);
                end else begin
                    if (res_y !== alu_model(qa[0], qb[0], qo[0]) || res_op !== qo[0]) begin
                        errors++;
                        $display("FAIL fill_order #%0d got y=%b op=%b required y=%b op=%b", got,
                                 res_y, res_op, alu_model(qa[0], qb[0], qo[0]), qo[0]);
                    end
                    void'(qa.pop_front()); void'(qb.pop_front()); void'(qo.pop_front());
                end
                got++;
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        checks++;
        if (got != 5 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_drain got=%0d busy=%b ready=%b required 5 0 1", got, busy, cmd_ready);
        end
    endtask

    task automatic test_random;
        localparam int N = 40;
        logic [5:0] exp_q [$];
        logic [3:0] op_q [$];
        int sent, got;
        sent = 0; got = 0;
        fork
            begin
                int guard;
                guard = 0;
                while (sent < N && guard < 3000) begin
                    @(negedge clk);
                    guard++;
                    cmd_valid = ($urandom_range(0, 3) != 0);
                    cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 4'($urandom);
                    if (cmd_valid && cmd_ready) begin
                        exp_q.push_back(alu_model(cmd_a, cmd_b, cmd_op));
                        op_q.push_back(cmd_op);
                        sent++;
                    end
                end
                @(negedge clk);
                cmd_valid = 1'b0;
            end
            begin
                int guard;
                bit held;
                logic [5:0] prev_y;
                guard = 0; held = 1'b0; prev_y = 6'd0;
                while (got < N && guard < 3000) begin
                    @(negedge clk);
                    guard++;
                    if (held) begin
                        checks++;
                        if (res_valid !== 1'b1 || res_y !== prev_y) begin
                            errors++;
                            $display("FAIL rand_stable v=%b y=%b required 1 %b", res_valid, res_y, prev_y);
                        end
                    end
                    res_ready = 1'($urandom_range(0, 1));
                    if (res_valid && res_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_extra y=%b required none", res_y);
                        end else begin
                            if (res_y !== exp_q[0] || res_op !== op_q[0]) begin
                                errors++;
                                $display("FAIL rand_result #%0d got y=%b op=%b required y=%b op=%b",
                                         got, res_y, res_op, exp_q[0], op_q[0]);
                            end
                            void'(exp_q.pop_front()); void'(op_q.pop_front());
                        end
                        got++;
                        held = 1'b0;
                    end else begin
                        held = res_valid;
                    end
                    prev_y = res_y;
                end
                res_ready = 1'b0;
            end
        join
        checks++;
        if (got != N || sent != N) begin
            errors++;
            $display("FAIL rand_count sent=%0d got=%0d required %0d", sent, got, N);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        bit ok;
        res_ready = 1'b0;
        push(4'd1, 4'd2, 4'd2);
        push(4'd3, 4'd4, 4'd2);
        push(4'd5, 4'd6, 4'd2);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_setup res_valid=%b required 1", res_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async v=%b ready=%b busy=%b required 0 1 0", res_valid, cmd_ready, busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale y=%b required no result", res_y);
            end
        end
        res_ready = 1'b0;
        test_single(4'b0111, 4'b0000, 4'b0111, 6'b011100, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single(4'b0111, 4'b0000, 4'b0000, 6'b001000, 1'b0, 1'b0);
        test_single(4'b1000, 4'b0000, 4'b0001, 6'b110111, 1'b0, 1'b1);
        test_single(4'b1111, 4'b0000, 4'b0000, 6'b000000, 1'b1, 1'b0);
        test_back_to_back();
        test_fill_backpressure();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
